// File: rtl/fetch_queue.sv
// fetch_queue: instruction fetch front end.
// Issues one sequential read per cycle while there is room for the response,
// buffers {inst, pc_plus1} pairs in a small circular FIFO, and flushes
// everything (queued entries and the in-flight read) on a redirect.
module fetch_queue #(
  parameter int            AW       = 16,
  parameter int            IW       = 16,
  parameter int            DEPTH    = 4,
  parameter logic [AW-1:0] RESET_PC = '0
) (
  input  logic                     clk,
  input  logic                     rst,
  output logic                     imem_req,
  output logic [AW-1:0]            imem_addr,
  input  logic [IW-1:0]            imem_rdata,
  input  logic                     redirect,
  input  logic [AW-1:0]            redirect_pc,
  output logic                     out_valid,
  output logic [IW-1:0]            out_inst,
  output logic [AW-1:0]            out_pc_plus1,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int            PW      = $clog2(DEPTH);
  localparam int            CW      = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [AW-1:0] fetch_pc;
  logic          inflight;
  logic [AW-1:0] inflight_pc1;
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [IW-1:0] inst_mem [DEPTH];
  logic [AW-1:0] pc1_mem  [DEPTH];

  logic          push;
  logic          pop;
  logic [CW-1:0] occupancy;

  // The in-flight read already owns a slot, so it counts against capacity.
  // A pop in the same cycle earns no credit, which keeps this path short.
  assign occupancy    = count + CW'(inflight);
  assign imem_req     = !rst && !redirect && (occupancy < DEPTH_C);
  assign imem_addr    = fetch_pc;

  // A redirect hides the head and squashes the response arriving this cycle.
  assign out_valid    = (count != '0) && !redirect;
  assign out_inst     = inst_mem[rd_ptr];
  assign out_pc_plus1 = pc1_mem[rd_ptr];

  assign push         = inflight && !redirect;
  assign pop          = out_valid && out_ready;

  // Fetch pointer, in-flight tracking, FIFO pointers and occupancy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc     <= RESET_PC;
      inflight     <= 1'b0;
      inflight_pc1 <= '0;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
    end else if (redirect) begin
      fetch_pc <= redirect_pc;
      inflight <= 1'b0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
    end else begin
      if (imem_req) begin
        fetch_pc     <= fetch_pc + AW'(1);
        inflight_pc1 <= fetch_pc + AW'(1);
      end
      inflight <= imem_req;
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Entry storage; no reset needed since count gates visibility.
  always_ff @(posedge clk) begin
    if (push) begin
      inst_mem[wr_ptr] <= imem_rdata;
      pc1_mem[wr_ptr]  <= inflight_pc1;
    end
  end

  // Occupancy can never exceed the queue depth.
  always @(posedge clk) begin
    if (!rst) assert (count <= DEPTH_C);
  end

endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: directed and randomized checks of fetch_queue with a
// one-cycle-latency instruction memory returning addr ^ 16'hA5A5.
module tb_fetch_queue;

  logic        clk;
  logic        rst;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic [15:0] imem_rdata;
  logic        redirect;
  logic [15:0] redirect_pc;
  logic        out_valid;
  logic [15:0] out_inst;
  logic [15:0] out_pc_plus1;
  logic        out_ready;
  logic [2:0]  count;

  int tests = 0;
  int fails = 0;
  logic [15:0] exp_pc1;

  fetch_queue #(.AW(16), .IW(16), .DEPTH(4), .RESET_PC(16'h0000)) dut (
    .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rdata(imem_rdata), .redirect(redirect), .redirect_pc(redirect_pc),
    .out_valid(out_valid), .out_inst(out_inst), .out_pc_plus1(out_pc_plus1),
    .out_ready(out_ready), .count(count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Memory model: data for a request appears in the following cycle.
  always @(posedge clk) begin
    imem_rdata <= imem_req ? (imem_addr ^ 16'hA5A5) : 16'h0000;
  end

  // Reset held across an edge, released at a falling edge (cycle 0 begins).
  task automatic reset_pulse();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; redirect = 1'b0; redirect_pc = 16'h0; out_ready = 1'b0;
    @(negedge clk);
    #1;
    tests++; if (imem_req !== 1'b0)  begin fails++; $display("FAIL reset_req got=%b exp=0", imem_req); end
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_valid got=%b exp=0", out_valid); end
    tests++; if (count !== 3'd0)     begin fails++; $display("FAIL reset_count got=%0d exp=0", count); end
    tests++; if (imem_addr !== 16'h0) begin fails++; $display("FAIL reset_addr got=%h exp=0000", imem_addr); end
  endtask

  task automatic test_stream();
    @(negedge clk);
    rst = 1'b0; out_ready = 1'b1;
    #1;
    tests++; if (imem_req !== 1'b1 || imem_addr !== 16'h0000)
      begin fails++; $display("FAIL stream_first_req got=%b/%h exp=1/0000", imem_req, imem_addr); end
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk); #1;
      if (k == 1) begin
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL stream_early_valid got=%b exp=0", out_valid); end
      end else begin
        tests++; if (out_valid !== 1'b1 || out_pc_plus1 !== 16'(k - 1) || out_inst !== (16'(k - 2) ^ 16'hA5A5))
          begin fails++; $display("FAIL stream_c%0d got=%b/%h/%h exp=1/%h/%h", k, out_valid, out_pc_plus1, out_inst, 16'(k - 1), 16'(k - 2) ^ 16'hA5A5); end
      end
    end
    exp_pc1 = 16'd12;
  endtask

  task automatic test_backpressure();
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      out_ready = 1'b0;
      #1;
    end
    tests++; if (count !== 3'd4)     begin fails++; $display("FAIL bp_count got=%0d exp=4", count); end
    tests++; if (imem_req !== 1'b0)  begin fails++; $display("FAIL bp_req got=%b exp=0", imem_req); end
    tests++; if (out_valid !== 1'b1 || out_pc_plus1 !== exp_pc1)
      begin fails++; $display("FAIL bp_head got=%b/%h exp=1/%h", out_valid, out_pc_plus1, exp_pc1); end
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      out_ready = 1'b1;
      #1;
      tests++; if (out_valid !== 1'b1 || out_pc_plus1 !== exp_pc1 || out_inst !== ((exp_pc1 - 16'd1) ^ 16'hA5A5))
        begin fails++; $display("FAIL bp_drain%0d got=%b/%h/%h exp=1/%h", k, out_valid, out_pc_plus1, out_inst, exp_pc1); end
      exp_pc1 = exp_pc1 + 16'd1;
    end
  endtask

  task automatic test_redirect();
    reset_pulse();
    out_ready = 1'b0;
    for (int k = 0; k < 4; k++) @(negedge clk);
    // cycle 4: three queued, one in flight
    redirect = 1'b1; redirect_pc = 16'h0040;
    #1;
    tests++; if (count !== 3'd3)    begin fails++; $display("FAIL redir_pre_count got=%0d exp=3", count); end
    tests++; if (out_valid !== 1'b0 || imem_req !== 1'b0)
      begin fails++; $display("FAIL redir_mask got=%b/%b exp=0/0", out_valid, imem_req); end
    @(negedge clk);
    redirect = 1'b0; out_ready = 1'b1;
    #1;
    tests++; if (count !== 3'd0)    begin fails++; $display("FAIL redir_count got=%0d exp=0", count); end
    tests++; if (imem_req !== 1'b1 || imem_addr !== 16'h0040)
      begin fails++; $display("FAIL redir_addr got=%b/%h exp=1/0040", imem_req, imem_addr); end
    @(negedge clk); #1;
    tests++; if (out_valid !== 1'b0 || count !== 3'd0)
      begin fails++; $display("FAIL redir_squash got=%b/%0d exp=0/0", out_valid, count); end
    @(negedge clk); #1;
    tests++; if (out_valid !== 1'b1 || out_pc_plus1 !== 16'h0041 || out_inst !== (16'h0040 ^ 16'hA5A5))
      begin fails++; $display("FAIL redir_first got=%b/%h/%h exp=1/0041/%h", out_valid, out_pc_plus1, out_inst, 16'h0040 ^ 16'hA5A5); end
    @(negedge clk); #1;
    tests++; if (out_valid !== 1'b1 || out_pc_plus1 !== 16'h0042)
      begin fails++; $display("FAIL redir_second got=%b/%h exp=1/0042", out_valid, out_pc_plus1); end
  endtask

  task automatic test_wrap();
    @(negedge clk);
    redirect = 1'b1; redirect_pc = 16'hFFFF; out_ready = 1'b1;
    @(negedge clk);
    redirect = 1'b0;
    #1;
    tests++; if (imem_addr !== 16'hFFFF) begin fails++; $display("FAIL wrap_addr0 got=%h exp=ffff", imem_addr); end
    @(negedge clk); #1;
    tests++; if (imem_req !== 1'b1 || imem_addr !== 16'h0000)
      begin fails++; $display("FAIL wrap_addr1 got=%b/%h exp=1/0000", imem_req, imem_addr); end
    @(negedge clk); #1;
    tests++; if (out_valid !== 1'b1 || out_pc_plus1 !== 16'h0000 || out_inst !== 16'h5A5A)
      begin fails++; $display("FAIL wrap_head got=%b/%h/%h exp=1/0000/5a5a", out_valid, out_pc_plus1, out_inst); end
    @(negedge clk); #1;
    tests++; if (out_valid !== 1'b1 || out_pc_plus1 !== 16'h0001 || out_inst !== 16'hA5A5)
      begin fails++; $display("FAIL wrap_next got=%b/%h/%h exp=1/0001/a5a5", out_valid, out_pc_plus1, out_inst); end
  endtask

  task automatic test_async_reset();
    reset_pulse();
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) @(negedge clk);
    #1;
    tests++; if (count !== 3'd2) begin fails++; $display("FAIL arst_pre_count got=%0d exp=2", count); end
    #1;
    rst = 1'b1;
    #1;
    tests++; if (out_valid !== 1'b0 || count !== 3'd0 || imem_req !== 1'b0)
      begin fails++; $display("FAIL arst_clear got=%b/%0d/%b exp=0/0/0", out_valid, count, imem_req); end
    @(negedge clk);
    rst = 1'b0; out_ready = 1'b1;
    #1;
    tests++; if (imem_req !== 1'b1 || imem_addr !== 16'h0000)
      begin fails++; $display("FAIL arst_restart got=%b/%h exp=1/0000", imem_req, imem_addr); end
    @(negedge clk); #1;
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL arst_no_partial got=%b exp=0", out_valid); end
    @(negedge clk); #1;
    tests++; if (out_valid !== 1'b1 || out_pc_plus1 !== 16'h0001 || out_inst !== 16'hA5A5)
      begin fails++; $display("FAIL arst_first got=%b/%h/%h exp=1/0001/a5a5", out_valid, out_pc_plus1, out_inst); end
  endtask

  task automatic test_random();
    logic [15:0] m_pc;
    logic [15:0] m_head;
    logic [2:0]  m_count;
    logic        m_inf;
    logic        m_req;
    logic        m_pop;
    logic        armed;
    int          pops;
    armed = 1'b0; pops = 0;
    m_pc = '0; m_head = '0; m_count = '0; m_inf = 1'b0;
    for (int c = 0; c < 10000; c++) begin
      @(negedge clk);
      out_ready   = ($urandom_range(0, 9) < 7);
      redirect    = (c == 0) || ($urandom_range(0, 99) < 5);
      redirect_pc = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(16'hFFFC, 16'hFFFF)) : 16'($urandom);
      #1;
      m_req = !redirect && ((m_count + {2'b00, m_inf}) < 3'd4);
      if (armed) begin
        tests++; if (count !== m_count || count > 3'd4)
          begin fails++; $display("FAIL rnd_count c=%0d got=%0d exp=%0d", c, count, m_count); end
        tests++; if (imem_req !== m_req || (m_req && imem_addr !== m_pc))
          begin fails++; $display("FAIL rnd_req c=%0d got=%b/%h exp=%b/%h", c, imem_req, imem_addr, m_req, m_pc); end
        tests++; if (out_valid !== (m_count != 3'd0 && !redirect))
          begin fails++; $display("FAIL rnd_valid c=%0d got=%b exp=%b", c, out_valid, (m_count != 3'd0 && !redirect)); end
        if (m_count != 3'd0 && !redirect) begin
          tests++; if (out_pc_plus1 !== m_head || out_inst !== ((m_head - 16'd1) ^ 16'hA5A5))
            begin fails++; $display("FAIL rnd_data c=%0d got=%h/%h exp=%h/%h", c, out_pc_plus1, out_inst, m_head, (m_head - 16'd1) ^ 16'hA5A5); end
        end
      end
      if (redirect) begin
        m_pc = redirect_pc; m_head = redirect_pc + 16'd1; m_count = '0; m_inf = 1'b0;
      end else begin
        m_pop = (m_count != 3'd0) && out_ready;
        if (m_pop) begin m_head = m_head + 16'd1; pops++; end
        m_count = m_count + {2'b00, m_inf} - {2'b00, m_pop};
        if (m_req) m_pc = m_pc + 16'd1;
        m_inf = m_req;
      end
      armed = 1'b1;
    end
    @(negedge clk);
    redirect = 1'b0;
    tests++; if (pops < 1000) begin fails++; $display("FAIL rnd_activity got=%0d exp>=1000", pops); end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect();
    test_wrap();
    test_async_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/fetch_queue.md
FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
- REQ-001: Parameter AW, default 16, instruction-address width.
- REQ-002: Parameter IW, default 16, instruction width.
- REQ-003: Parameter DEPTH, default 4, queue entries; power of two, >= 2.
- REQ-004: Parameter RESET_PC, default 0, first fetch address after reset.
- REQ-005: Port clk, input, 1, sole clock; all state changes on its rising edge.
- REQ-006: Port rst, input, 1, asynchronous active-high reset.
- REQ-007: Port imem_req, output, 1, instruction-memory read request this cycle.
- REQ-008: Port imem_addr, output, AW, read address; equals fetch_pc.
- REQ-009: Port imem_rdata, input, IW, read data, valid exactly one cycle after the matching imem_req.
- REQ-010: Port redirect, input, 1, branch/jump taken; flush and refetch.
- REQ-011: Port redirect_pc, input, AW, new fetch address, sampled when redirect=1.
- REQ-012: Port out_valid, output, 1, head entry available to decode.
- REQ-013: Port out_inst, output, IW, head instruction.
- REQ-014: Port out_pc_plus1, output, AW, head instruction address + 1, modulo 2^AW.
- REQ-015: Port out_ready, input, 1, decode accepts the head; pop = out_valid & out_ready.
- REQ-016: Port count, output, clog2(DEPTH)+1, current number of queued entries.

Function
- REQ-017: The block SHALL hold fetch_pc (AW), an in-flight flag, in-flight pc_plus1 (AW), and a DEPTH-entry circular FIFO of {inst, pc_plus1} with read/write pointers that wrap modulo DEPTH.
- REQ-018: imem_req SHALL equal !rst & !redirect & ((count + inflight) < DEPTH); there is no credit for a same-cycle pop.
- REQ-019: On an issue, the block SHALL increment fetch_pc by 1 modulo 2^AW, set inflight, and latch fetch_pc+1 as the in-flight pc_plus1; with no issue, inflight SHALL clear at the next edge.
- REQ-020: In the cycle after an issue, the block SHALL push imem_rdata and the latched pc_plus1 at the write pointer, unless the fetch is squashed.
- REQ-021: out_valid SHALL equal (count != 0) & !redirect; out_inst and out_pc_plus1 SHALL be read combinationally from the read pointer.
- REQ-022: With a simultaneous push and pop, count SHALL remain unchanged and both pointers SHALL advance.
- REQ-023: A push SHALL never overflow; REQ-018 guarantees this, and the assertion count <= DEPTH SHALL always hold.
- REQ-024: When out_valid=0, a pop SHALL have no effect.
- REQ-025: On redirect=1 at cycle t, at edge t+1 the block SHALL set fetch_pc=redirect_pc, count=0, both pointers equal, and inflight=0. Any response arriving in cycle t+1 from an issue before t SHALL be discarded (squashed), and no pop SHALL occur in cycle t.
- REQ-026: Redirect latency: imem_req=1 with imem_addr=redirect_pc in cycle t+1, and out_valid=1 with that instruction in cycle t+3.
- REQ-027: With DEPTH >= 3 and out_ready held at 1, the steady state SHALL deliver one instruction per cycle in address order.
- REQ-028: Redirect SHALL take priority over push, pop and issue in the same cycle.

Reset
- REQ-029: While rst=1 (asynchronous assertion): fetch_pc=RESET_PC, inflight=0, count=0, pointers=0, imem_req=0, out_valid=0.
- REQ-030: In the first cycle after rst deasserts, imem_req=1 with imem_addr=RESET_PC; out_valid SHALL first rise two cycles later.
- REQ-031: Reset asserted mid-operation SHALL discard all queued and in-flight state immediately, with no partial push.

Verification
- REQ-032: Reset then out_ready=1, memory returns inst=addr^16'hA5A5 -> out_valid from cycle 2; out_pc_plus1 = 1, 2, 3, ... consecutively, with no gaps after fill.
- REQ-033: out_ready=0 for 10 cycles (DEPTH=4) -> count saturates at 4 and imem_req=0 while count+inflight=4; release -> entries 0..3 pop in order, with no loss or duplicate.
- REQ-034: redirect=1 with redirect_pc=16'h0040 while count=3 and inflight=1 -> next cycle count=0; the squashed response is not queued; imem_addr=16'h0040; first out_pc_plus1=16'h0041 three cycles after redirect.
- REQ-035: fetch_pc=16'hFFFF -> next issued address 16'h0000; out_pc_plus1 for the 16'hFFFF entry = 16'h0000.
- REQ-036: rst pulsed asynchronously between edges with count=2 -> out_valid=0 and count=0 within the same cycle; restart fetches from RESET_PC.
- REQ-037: Random out_ready and redirect over 10k cycles vs. reference model -> delivered {inst, pc_plus1} stream matches, and count <= DEPTH always.
